// File: rtl/harmonic_mixer_pkg.sv
// harmonic_mixer_pkg: shared state encoding, datapath widths and saturation limits for the harmonic mixer
package harmonic_mixer_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_READY, SETTLE, ACCUM, OUTPUT} state_t;
  localparam int ACC_W = 24;
  localparam int GAIN_W = 16;
  localparam logic [GAIN_W-1:0] GAIN_INIT = 16'h7FFF;
  localparam logic signed [ACC_W-1:0] SAT_HI = 24'sh007FFF;
  localparam logic signed [ACC_W-1:0] SAT_LO = 24'shFF8000;
endpackage

// File: rtl/harmonic_gain.sv
// harmonic_gain: per-harmonic gain register, reloaded at sweep start and decayed once per harmonic
import harmonic_mixer_pkg::*;

module harmonic_gain (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Load,
  input  logic              i_Step,
  input  logic [GAIN_W-1:0] i_Decay,
  output logic [GAIN_W-1:0] o_Gain
);
  logic [GAIN_W-1:0]   r_Gain;
  logic [GAIN_W-1:0]   r_Decay;
  logic [2*GAIN_W-1:0] w_Product;

  assign w_Product = {{GAIN_W{1'b0}}, r_Gain} * {{GAIN_W{1'b0}}, r_Decay};
  assign o_Gain = r_Gain;

  // load full-scale gain and latch decay at sweep start; scale gain by decay (Q0.16) per harmonic
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Gain  <= '0;
      r_Decay <= '0;
    end else if (i_Load) begin
      r_Gain  <= GAIN_INIT;
      r_Decay <= i_Decay;
    end else if (i_Step) begin
      r_Gain  <= GAIN_W'(w_Product >> GAIN_W);
    end
  end
endmodule

// File: rtl/harmonic_mixer.sv
// harmonic_mixer: sums decaying sine harmonics into one saturated output sample per sweep
// Optional FREQ_LIMIT_EN: i_Freq_Too_High in ACCUM drops the term and ends the sweep early.
import harmonic_mixer_pkg::*;

module harmonic_mixer #(
  parameter int NUM_HARMONICS = 64,
  parameter int OUT_SHIFT     = 3
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Sample_Clock,
  input  logic [15:0] i_Decay,
  input  logic        i_Sample_Ready,
  input  logic [15:0] i_Sample_Value,
  input  logic        i_Freq_Too_High,
  output logic [7:0]  o_Harmonic,
  output logic        o_Next_Sample,
  output logic [15:0] o_Output_Sample,
  output logic        o_Output_Valid,
  output logic        o_Overrun
);
  state_t                   r_State, w_Next_State;
  logic signed [ACC_W-1:0]  r_Acc;
  logic [7:0]               r_Harmonic;
  logic                     r_Next_Sample, r_Output_Valid, r_Overrun;
  logic [15:0]              r_Output_Sample;
  logic [GAIN_W-1:0]        w_Gain;
  logic signed [31:0]       w_Product;
  logic signed [ACC_W-1:0]  w_Acc_Next, w_Shifted;
  logic [15:0]              w_Sat;
  logic                     w_Last, w_Stop, w_Start;

`ifdef FREQ_LIMIT_EN
  assign w_Stop = i_Freq_Too_High;
`else
  assign w_Stop = 1'b0 & i_Freq_Too_High;
`endif

  assign w_Start    = (r_State == IDLE) && i_Sample_Clock;
  assign w_Last     = r_Harmonic == 8'(NUM_HARMONICS - 1);
  assign w_Product  = $signed({{16{i_Sample_Value[15]}}, i_Sample_Value}) * $signed({16'd0, w_Gain});
  assign w_Acc_Next = r_Acc + ACC_W'(w_Product >>> 15);
  assign w_Shifted  = r_Acc >>> OUT_SHIFT;
  assign w_Sat      = (w_Shifted > SAT_HI) ? 16'h7FFF : (w_Shifted < SAT_LO) ? 16'h8000 : 16'(w_Shifted);

  harmonic_gain u_gain (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Load  (w_Start),
    .i_Step  (r_State == ACCUM),
    .i_Decay (i_Decay),
    .o_Gain  (w_Gain)
  );

  // state register
  always_ff @(posedge i_Clock) begin
    r_State <= i_Reset ? IDLE : w_Next_State;
  end

  // next state; a ready seen while o_Next_Sample is still high is stale and ignored
  always_comb begin
    w_Next_State = r_State;
    unique case (r_State)
      IDLE:       w_Next_State = i_Sample_Clock ? WAIT_READY : IDLE;
      WAIT_READY: w_Next_State = (i_Sample_Ready && !r_Next_Sample) ? SETTLE : WAIT_READY;
      SETTLE:     w_Next_State = ACCUM;
      ACCUM:      w_Next_State = (w_Last || w_Stop) ? OUTPUT : WAIT_READY;
      OUTPUT:     w_Next_State = IDLE;
      default:    w_Next_State = IDLE;
    endcase
  end

  // accumulator, harmonic index and output pulses
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Acc           <= '0;
      r_Harmonic      <= '0;
      r_Next_Sample   <= 1'b0;
      r_Output_Valid  <= 1'b0;
      r_Overrun       <= 1'b0;
      r_Output_Sample <= '0;
    end else begin
      r_Next_Sample  <= r_State == ACCUM;
      r_Output_Valid <= r_State == OUTPUT;
      r_Overrun      <= i_Sample_Clock && (r_State != IDLE);
      if (w_Start) r_Acc <= '0;
      if (r_State == ACCUM) begin
        r_Acc      <= w_Stop ? r_Acc : w_Acc_Next;
        r_Harmonic <= (w_Last || w_Stop) ? 8'd0 : r_Harmonic + 8'd1;
      end
      if (r_State == OUTPUT) r_Output_Sample <= w_Sat;
    end
  end

  assign o_Harmonic      = r_Harmonic;
  assign o_Next_Sample   = r_Next_Sample;
  assign o_Output_Sample = r_Output_Sample;
  assign o_Output_Valid  = r_Output_Valid;
  assign o_Overrun       = r_Overrun;
endmodule

// File: tb/tb_harmonic_mixer.sv
// tb_harmonic_mixer: directed checks on three mixer instances (1, 3 and 64 harmonics)
module tb_harmonic_mixer;
  logic        clk = 0;
  logic        rst = 1;
  logic        sc [3];
  logic        ready = 0;
  logic [15:0] value = 0;
  logic [15:0] decay = 0;
  logic        ftoo_en = 0;
  logic [7:0]  h [3];
  logic        ns [3];
  logic [15:0] os [3];
  logic        ov [3];
  logic        orr [3];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  harmonic_mixer #(.NUM_HARMONICS(1)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Sample_Clock(sc[0]), .i_Decay(decay),
    .i_Sample_Ready(ready), .i_Sample_Value(value), .i_Freq_Too_High(1'b0),
    .o_Harmonic(h[0]), .o_Next_Sample(ns[0]), .o_Output_Sample(os[0]),
    .o_Output_Valid(ov[0]), .o_Overrun(orr[0]));

  harmonic_mixer #(.NUM_HARMONICS(3)) u3 (
    .i_Clock(clk), .i_Reset(rst), .i_Sample_Clock(sc[1]), .i_Decay(decay),
    .i_Sample_Ready(ready), .i_Sample_Value(value), .i_Freq_Too_High(ftoo_en && h[1] == 8'd2),
    .o_Harmonic(h[1]), .o_Next_Sample(ns[1]), .o_Output_Sample(os[1]),
    .o_Output_Valid(ov[1]), .o_Overrun(orr[1]));

  harmonic_mixer #(.NUM_HARMONICS(64)) u64 (
    .i_Clock(clk), .i_Reset(rst), .i_Sample_Clock(sc[2]), .i_Decay(decay),
    .i_Sample_Ready(ready), .i_Sample_Value(value), .i_Freq_Too_High(1'b0),
    .o_Harmonic(h[2]), .o_Next_Sample(ns[2]), .o_Output_Sample(os[2]),
    .o_Output_Valid(ov[2]), .o_Overrun(orr[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int k, output logic [15:0] res, output int npulse, output int hmax);
    bit got = 0;
    npulse = 0;
    hmax = 0;
    sc[k] = 1;
    tick();
    sc[k] = 0;
    for (int n = 0; n < 2000 && !got; n++) begin
      if (ov[k]) got = 1;
      else begin
        if (ns[k]) npulse++;
        if (int'(h[k]) > hmax) hmax = int'(h[k]);
        tick();
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL sweep_timeout inst=%0d got=no_valid required=valid", k); end
    res = os[k];
    tick();
    checks++;
    if (ov[k] !== 1'b0) begin errors++; $display("FAIL valid_width inst=%0d got=%b required=0", k, ov[k]); end
  endtask

  task automatic test_reset_state();
    repeat (2) tick();
    checks++;
    if (os[0] !== 16'h0 || os[1] !== 16'h0 || os[2] !== 16'h0 || ov[2] !== 1'b0 || h[2] !== 8'h0 || ns[2] !== 1'b0 || orr[2] !== 1'b0) begin
      errors++; $display("FAIL reset_state got os=%h h=%h ns=%b ov=%b or=%b required all 0", os[2], h[2], ns[2], ov[2], orr[2]);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_single();
    logic [15:0] r; int np, hm;
    ready = 1; value = 16'h4000; decay = 16'h8000;
    run(0, r, np, hm);
    checks++; if (r !== 16'h07FF) begin errors++; $display("FAIL single_value got=%h required=07ff", r); end
    checks++; if (np !== 1) begin errors++; $display("FAIL single_next_pulses got=%0d required=1", np); end
    checks++; if (hm !== 0) begin errors++; $display("FAIL single_harmonic got=%0d required=0", hm); end
  endtask

  task automatic test_three();
    logic [15:0] r; int np, hm;
    ready = 1; value = 16'h4000; decay = 16'h8000;
    run(1, r, np, hm);
    checks++; if (r !== 16'h0DFF) begin errors++; $display("FAIL three_value got=%h required=0dff", r); end
    checks++; if (np !== 3) begin errors++; $display("FAIL three_next_pulses got=%0d required=3", np); end
    checks++; if (hm !== 2) begin errors++; $display("FAIL three_max_harmonic got=%0d required=2", hm); end
    checks++; if (h[1] !== 8'd0) begin errors++; $display("FAIL three_harmonic_wrap got=%0d required=0", h[1]); end
  endtask

  task automatic test_saturate();
    logic [15:0] r; int np, hm;
    ready = 1; decay = 16'hFFFF; value = 16'h7FFF;
    run(2, r, np, hm);
    checks++; if (r !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got=%h required=7fff", r); end
    checks++; if (np !== 64) begin errors++; $display("FAIL sat_next_pulses got=%0d required=64", np); end
    value = 16'h8000;
    run(2, r, np, hm);
    checks++; if (r !== 16'h8000) begin errors++; $display("FAIL sat_neg got=%h required=8000", r); end
  endtask

  task automatic test_decay_zero();
    logic [15:0] r; int np, hm;
    ready = 1; value = 16'h4000; decay = 16'h0000;
    run(1, r, np, hm);
    checks++; if (r !== 16'h07FF) begin errors++; $display("FAIL decay0_value got=%h required=07ff", r); end
    checks++; if (np !== 3) begin errors++; $display("FAIL decay0_next_pulses got=%0d required=3", np); end
  endtask

  task automatic test_freq_limit();
    logic [15:0] r; int np, hm;
    ready = 1; value = 16'h4000; decay = 16'h8000; ftoo_en = 1;
    run(1, r, np, hm);
    ftoo_en = 0;
`ifdef FREQ_LIMIT_EN
    checks++; if (r !== 16'h0BFF) begin errors++; $display("FAIL freq_limit_value got=%h required=0bff", r); end
`else
    checks++; if (r !== 16'h0DFF) begin errors++; $display("FAIL freq_ignored_value got=%h required=0dff", r); end
`endif
    checks++; if (np !== 3) begin errors++; $display("FAIL freq_next_pulses got=%0d required=3", np); end
    checks++; if (h[1] !== 8'd0) begin errors++; $display("FAIL freq_harmonic got=%0d required=0", h[1]); end
  endtask

  task automatic test_overrun();
    bit got = 0;
    ready = 0; value = 16'h4000; decay = 16'h8000;
    sc[1] = 1; tick(); sc[1] = 0;
    tick();
    decay = 16'h0000;
    sc[1] = 1; tick(); sc[1] = 0;
    checks++; if (orr[1] !== 1'b1) begin errors++; $display("FAIL overrun_pulse got=%b required=1", orr[1]); end
    tick();
    checks++; if (orr[1] !== 1'b0) begin errors++; $display("FAIL overrun_width got=%b required=0", orr[1]); end
    ready = 1;
    for (int n = 0; n < 200 && !got; n++) begin
      if (ov[1]) got = 1; else tick();
    end
    checks++; if (!got || os[1] !== 16'h0DFF) begin errors++; $display("FAIL overrun_result got=%h valid=%b required=0dff", os[1], got); end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    logic [15:0] r; int np, hm;
    bit seen = 0;
    ready = 1; value = 16'h4000; decay = 16'h8000;
    sc[2] = 1; tick(); sc[2] = 0;
    repeat (20) tick();
    rst = 1;
    tick();
    checks++;
    if (os[2] !== 16'h0 || h[2] !== 8'h0 || ns[2] !== 1'b0 || ov[2] !== 1'b0 || orr[2] !== 1'b0) begin
      errors++; $display("FAIL mid_reset got os=%h h=%h ns=%b ov=%b or=%b required all 0", os[2], h[2], ns[2], ov[2], orr[2]);
    end
    rst = 0;
    for (int n = 0; n < 300; n++) begin
      if (ov[2]) seen = 1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_reset_no_output got=valid required=none"); end
    run(1, r, np, hm);
    checks++; if (r !== 16'h0DFF) begin errors++; $display("FAIL post_reset_sweep got=%h required=0dff", r); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) sc[i] = 0;
    test_reset_state();
    test_single();
    test_three();
    test_saturate();
    test_decay_zero();
    test_freq_limit();
    test_overrun();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
